// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction ROM fetch and IF/ID register with stall, redirect and HLT freeze
module fetch_unit #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    output logic [3:0]  opcode,
    output logic [3:0]  load_save_reg,
    output logic [2:0]  branch_cond,
    output logic [3:0]  reg_rs,
    output logic [3:0]  reg_rt,
    output logic [7:0]  load_save_imm,
    output logic [11:0] call_target,
    output logic [15:0] pc_out,
    output logic        pc_update,
    output logic        halted,
    output logic [15:0] fetch_count
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [15:0] r_ir, w_ir_nxt;
    logic [15:0] r_ir_pc, w_ir_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        w_pc_upd, w_is_hlt;

    assign w_pc_inc = r_pc + 16'd1;
    assign w_is_hlt = imem_data[15:12] == HLT_OPCODE;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_ir_pc_nxt = r_ir_pc;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_pc_upd    = 1'b0;
        if (redirect_valid) begin
            w_pc_nxt    = redirect_target;
            w_ir_nxt    = NOP_INSTR;
            w_ir_pc_nxt = 16'h0000;
            w_valid_nxt = 1'b0;
            w_state_nxt = RUN;
            w_pc_upd    = 1'b1;
        end else if (r_state == HALT) begin
            w_ir_nxt    = NOP_INSTR;
            w_ir_pc_nxt = 16'h0000;
            w_valid_nxt = 1'b0;
        end else if (!hazard) begin
            w_ir_nxt    = imem_data;
            w_ir_pc_nxt = w_pc_inc;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            // HLT is latched as a real instruction but the PC parks on it
            w_state_nxt = w_is_hlt ? HALT : RUN;
            w_pc_nxt    = w_is_hlt ? r_pc : w_pc_inc;
            w_pc_upd    = !w_is_hlt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= PC_RESET;
            r_ir    <= NOP_INSTR;
            r_ir_pc <= 16'h0000;
            r_valid <= 1'b0;
            r_cnt   <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_ir_pc <= w_ir_pc_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign imem_addr     = r_pc;
    assign pc_update     = w_pc_upd & ~rst;
    assign instr_valid   = r_valid;
    assign opcode        = r_ir[15:12];
    assign load_save_reg = r_ir[11:8];
    assign branch_cond   = r_ir[10:8];
    assign reg_rs        = r_ir[7:4];
    assign reg_rt        = r_ir[3:0];
    assign load_save_imm = r_ir[7:0];
    assign call_target   = r_ir[11:0];
    assign pc_out        = r_ir_pc;
    assign halted        = r_state == HALT;
    assign fetch_count   = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit, plus a wrap-around instance with PC_RESET=FFFF
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic [15:0] imem_addr, imem_data, pc_out, fetch_count, call_target_w;
    logic        instr_valid, pc_update, halted;
    logic [3:0]  opcode, load_save_reg, reg_rs, reg_rt;
    logic [2:0]  branch_cond;
    logic [7:0]  load_save_imm;
    logic [11:0] call_target;
    logic [15:0] w_addr, w_data, w_pc_out, w_cnt;
    logic        w_valid, w_pc_upd, w_halted;
    logic [3:0]  w_op, w_lsr, w_rs, w_rt;
    logic [2:0]  w_bc;
    logic [7:0]  w_imm;
    logic [11:0] w_ct;
    logic [15:0] rom [0:65535];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {logic [15:0] word; logic [15:0] pc; logic v;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];
    assign w_data    = rom[w_addr];

    fetch_unit dut (
        .clk(clk), .rst(rst), .hazard(hazard), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_valid(instr_valid), .opcode(opcode), .load_save_reg(load_save_reg),
        .branch_cond(branch_cond), .reg_rs(reg_rs), .reg_rt(reg_rt),
        .load_save_imm(load_save_imm), .call_target(call_target), .pc_out(pc_out),
        .pc_update(pc_update), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_unit #(.PC_RESET(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst), .hazard(1'b0), .redirect_valid(1'b0),
        .redirect_target(16'h0000), .imem_addr(w_addr), .imem_data(w_data),
        .instr_valid(w_valid), .opcode(w_op), .load_save_reg(w_lsr),
        .branch_cond(w_bc), .reg_rs(w_rs), .reg_rt(w_rt),
        .load_save_imm(w_imm), .call_target(w_ct), .pc_out(w_pc_out),
        .pc_update(w_pc_upd), .halted(w_halted), .fetch_count(w_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input logic [15:0] p, input logic v);
        exp_t e;
        e.word = w; e.pc = p; e.v = v;
        q.push_back(e);
    endtask

    task automatic check_ifid(input string tag);
        exp_t e;
        logic [15:0] w;
        n_chk++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_empty observed=0 expected=1 entries", tag);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            w = e.word;
            chk({tag, "_valid"}, 32'(instr_valid), 32'(e.v));
            chk({tag, "_pc"}, 32'(pc_out), 32'(e.pc));
            chk({tag, "_op"}, 32'(opcode), 32'(w[15:12]));
            chk({tag, "_lsr"}, 32'(load_save_reg), 32'(w[11:8]));
            chk({tag, "_bc"}, 32'(branch_cond), 32'(w[10:8]));
            chk({tag, "_rs"}, 32'(reg_rs), 32'(w[7:4]));
            chk({tag, "_rt"}, 32'(reg_rt), 32'(w[3:0]));
            chk({tag, "_imm"}, 32'(load_save_imm), 32'(w[7:0]));
            chk({tag, "_ct"}, 32'(call_target), 32'(w[11:0]));
        end
    endtask

    task automatic step(input string tag);
        tick();
        check_ifid(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1123; rom[1] = 16'h2456; rom[2] = 16'h3789; rom[3] = 16'h4ABC;
        rom[4] = 16'h5DEF; rom[5] = 16'hF000; rom[16'h10] = 16'h7123; rom[16'h40] = 16'h6A5B;
        tick();
        chk("rst_pc_update", 32'(pc_update), 0);
        chk("rst_w_pc_update", 32'(w_pc_upd), 0);
        push(16'h0000, 16'h0000, 1'b0);
        check_ifid("reset");
        chk("reset_addr", 32'(imem_addr), 32'h0000);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_cnt", 32'(fetch_count), 0);
        chk("w_reset_addr", 32'(w_addr), 32'hFFFF);
        rst = 1'b0;
        #1;
        chk("run_pc_update", 32'(pc_update), 1);
        push(16'h1123, 16'h0001, 1'b1);
        step("fetch0");
        chk("w_wrap_pc_out", 32'(w_pc_out), 32'h0000);
        chk("w_wrap_addr", 32'(w_addr), 32'h0000);
        chk("w_wrap_valid", 32'(w_valid), 1);
        chk("fetch0_addr", 32'(imem_addr), 32'h0001);
        push(16'h2456, 16'h0002, 1'b1);
        step("fetch1");
        chk("fetch1_addr", 32'(imem_addr), 32'h0002);
        hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("haz_pc_update", 32'(pc_update), 0);
            push(16'h2456, 16'h0002, 1'b1);
            step("hazard");
            chk("haz_addr", 32'(imem_addr), 32'h0002);
            chk("haz_cnt", 32'(fetch_count), 32'd2);
        end
        hazard = 1'b0;
        push(16'h3789, 16'h0003, 1'b1);
        step("resume");
        chk("resume_cnt", 32'(fetch_count), 32'd3);
        hazard = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 16'h0040;
        #1;
        chk("redir_haz_pc_update", 32'(pc_update), 1);
        push(16'h0000, 16'h0000, 1'b0);
        step("redir_bubble");
        chk("redir_addr", 32'(imem_addr), 32'h0040);
        hazard = 1'b0;
        redirect_valid = 1'b0;
        push(16'h6A5B, 16'h0041, 1'b1);
        step("redir_target");
        chk("redir_cnt", 32'(fetch_count), 32'd4);
        redirect_valid = 1'b1;
        redirect_target = 16'h0003;
        push(16'h0000, 16'h0000, 1'b0);
        step("to3_bubble");
        redirect_valid = 1'b0;
        push(16'h4ABC, 16'h0004, 1'b1);
        step("fetch3");
        push(16'h5DEF, 16'h0005, 1'b1);
        step("fetch4");
        #1;
        chk("hlt_pc_update", 32'(pc_update), 0);
        push(16'hF000, 16'h0006, 1'b1);
        step("hlt");
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_addr", 32'(imem_addr), 32'h0005);
        chk("hlt_cnt", 32'(fetch_count), 32'd7);
        for (int i = 0; i < 2; i++) begin
            chk("halt_pc_update", 32'(pc_update), 0);
            push(16'h0000, 16'h0000, 1'b0);
            step("halt_bubble");
            chk("halt_addr", 32'(imem_addr), 32'h0005);
            chk("halt_halted", 32'(halted), 1);
            chk("halt_cnt", 32'(fetch_count), 32'd7);
        end
        redirect_valid = 1'b1;
        redirect_target = 16'h0010;
        #1;
        chk("unhalt_pc_update", 32'(pc_update), 1);
        push(16'h0000, 16'h0000, 1'b0);
        step("unhalt_bubble");
        chk("unhalt_halted", 32'(halted), 0);
        chk("unhalt_addr", 32'(imem_addr), 32'h0010);
        redirect_valid = 1'b0;
        push(16'h7123, 16'h0011, 1'b1);
        step("unhalt_fetch");
        chk("unhalt_cnt", 32'(fetch_count), 32'd8);
        rom[5] = 16'h0000;
        for (int i = 0; i < 65526; i++) tick();
        chk("sat_pre", 32'(fetch_count), 32'hFFFE);
        chk("sat_pre_addr", 32'(imem_addr), 32'h0007);
        tick();
        chk("sat_hit", 32'(fetch_count), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(fetch_count), 32'hFFFF);
        rom[9] = 16'hF123;
        push(16'hF123, 16'h000A, 1'b1);
        step("sat_hlt");
        chk("sat_hlt_halted", 32'(halted), 1);
        chk("sat_hlt_cnt", 32'(fetch_count), 32'hFFFF);
        rst = 1'b1;
        hazard = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 16'h0077;
        #1;
        chk("rst2_pc_update", 32'(pc_update), 0);
        push(16'h0000, 16'h0000, 1'b0);
        step("rst2");
        chk("rst2_addr", 32'(imem_addr), 32'h0000);
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_cnt", 32'(fetch_count), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
